// File: rtl/rx_ipv4_if.sv
// Byte-wide AXI-Stream bundle shared by the input and payload sides of rx_ipv4.
`timescale 1ns/1ps
interface rx_ipv4_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_ipv4.sv
// IPv4 header stripper: parses and validates the header, forwards only the payload
// through a single output register, and drops rejected frames up to their tlast.
`timescale 1ns/1ps
module rx_ipv4 #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80102,
  parameter logic [7:0]  PROTOCOL   = 8'h11,
  parameter bit          CHECK_DEST = 1'b1
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic        ip_enable,
  rx_ipv4_if.slave    s_axis,
  rx_ipv4_if.master   m_axis,
  output logic [31:0] IP_SrcAddr,
  output logic [31:0] IP_DestAddr,
  output logic [15:0] IP_TotLen,
  output logic [7:0]  IP_Protocol,
  output logic [7:0]  IP_TTL,
  output logic [3:0]  IP_HdrLen,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {IDLE, HEADER, OPTIONS, PAYLOAD, DROP} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [15:0] csum;
  logic [7:0]  csum_hi;
  logic [3:0]  ver_sh, ihl_sh;
  logic [15:0] totlen_sh, frag_sh;
  logic [7:0]  ttl_sh, proto_sh;
  logic [31:0] src_sh, dst_sh;
  logic [15:0] remaining;
  logic        first_byte;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_user;

  logic        core_ready, accept, hdr_last;
  logic [16:0] csum_add;
  logic [15:0] csum_next, hdr_bytes;
  logic [31:0] dst_now;
  logic [2:0]  val_err;

  assign core_ready = (state == PAYLOAD) ? (~out_valid | m_axis.tready) : 1'b1;
  assign accept     = s_axis.tvalid & core_ready;

  assign s_axis.tready = ip_enable ? core_ready : m_axis.tready;
  assign m_axis.tdata  = ip_enable ? out_data  : s_axis.tdata;
  assign m_axis.tvalid = ip_enable ? out_valid : s_axis.tvalid;
  assign m_axis.tlast  = ip_enable ? out_last  : s_axis.tlast;
  assign m_axis.tuser  = ip_enable ? out_user  : s_axis.tuser;

  // One end-around-carry fold per word keeps the running sum within 16 bits.
  assign csum_add  = {1'b0, csum} + {1'b0, csum_hi, s_axis.tdata};
  assign csum_next = csum_add[15:0] + {15'd0, csum_add[16]};

  assign hdr_bytes = {10'd0, ihl_sh, 2'b00};
  assign dst_now   = (state == HEADER) ? {dst_sh[23:0], s_axis.tdata} : dst_sh;
  assign hdr_last  = ((state == HEADER) && (cnt == 6'd19) && (ihl_sh <= 4'd5)) ||
                     ((state == OPTIONS) && (cnt == ({ihl_sh, 2'b00} - 6'd1)));

  // Evaluated on the final header/option byte, so the sum includes that byte.
  always_comb begin
    val_err = 3'd0;
    if ((ver_sh != 4'd4) || (ihl_sh < 4'd5) || (totlen_sh <= hdr_bytes))
      val_err = 3'd1;
    else if (csum_next != 16'hFFFF)
      val_err = 3'd2;
    else if ((proto_sh != PROTOCOL) ||
             (CHECK_DEST && (dst_now != LOCAL_IP) && (dst_now != 32'hFFFFFFFF)))
      val_err = 3'd3;
    else if (frag_sh[13] || (frag_sh[12:0] != 13'd0))
      val_err = 3'd4;
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state       <= IDLE;
      cnt         <= '0;
      csum        <= '0;
      csum_hi     <= '0;
      ver_sh      <= '0;
      ihl_sh      <= '0;
      totlen_sh   <= '0;
      frag_sh     <= '0;
      ttl_sh      <= '0;
      proto_sh    <= '0;
      src_sh      <= '0;
      dst_sh      <= '0;
      remaining   <= '0;
      first_byte  <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_user    <= 1'b0;
      IP_SrcAddr  <= '0;
      IP_DestAddr <= '0;
      IP_TotLen   <= '0;
      IP_Protocol <= '0;
      IP_TTL      <= '0;
      IP_HdrLen   <= '0;
      pkt_ok      <= 1'b0;
      pkt_err     <= 1'b0;
      err_code    <= '0;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      if (m_axis.tready)
        out_valid <= 1'b0;
      if (!ip_enable) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else if (accept) begin
        case (state)
          IDLE: begin
            if (s_axis.tuser) begin
              if (s_axis.tlast) begin
                pkt_err  <= 1'b1;
                err_code <= 3'd5;
              end else begin
                state      <= HEADER;
                cnt        <= 6'd1;
                csum       <= '0;
                csum_hi    <= s_axis.tdata;
                ver_sh     <= s_axis.tdata[7:4];
                ihl_sh     <= s_axis.tdata[3:0];
                first_byte <= 1'b1;
              end
            end
          end
          HEADER, OPTIONS: begin
            cnt <= cnt + 6'd1;
            if (cnt[0])
              csum <= csum_next;
            else
              csum_hi <= s_axis.tdata;
            if (state == HEADER) begin
              case (cnt)
                6'd2:  totlen_sh[15:8] <= s_axis.tdata;
                6'd3:  totlen_sh[7:0]  <= s_axis.tdata;
                6'd6:  frag_sh[15:8]   <= s_axis.tdata;
                6'd7:  frag_sh[7:0]    <= s_axis.tdata;
                6'd8:  ttl_sh          <= s_axis.tdata;
                6'd9:  proto_sh        <= s_axis.tdata;
                6'd12, 6'd13, 6'd14, 6'd15: src_sh <= {src_sh[23:0], s_axis.tdata};
                6'd16, 6'd17, 6'd18, 6'd19: dst_sh <= {dst_sh[23:0], s_axis.tdata};
                default: ;
              endcase
            end
            if (s_axis.tlast) begin
              pkt_err  <= 1'b1;
              err_code <= 3'd5;
              state    <= IDLE;
            end else if (hdr_last) begin
              if (val_err == 3'd0) begin
                IP_SrcAddr  <= src_sh;
                IP_DestAddr <= dst_now;
                IP_TotLen   <= totlen_sh;
                IP_Protocol <= proto_sh;
                IP_TTL      <= ttl_sh;
                IP_HdrLen   <= ihl_sh;
                pkt_ok      <= 1'b1;
                remaining   <= totlen_sh - hdr_bytes;
                state       <= PAYLOAD;
              end else begin
                pkt_err  <= 1'b1;
                err_code <= val_err;
                state    <= DROP;
              end
            end else if ((state == HEADER) && (cnt == 6'd19)) begin
              state <= OPTIONS;
            end
          end
          PAYLOAD: begin
            out_data   <= s_axis.tdata;
            out_valid  <= 1'b1;
            out_user   <= first_byte;
            out_last   <= (remaining == 16'd1) | s_axis.tlast;
            first_byte <= 1'b0;
            remaining  <= remaining - 16'd1;
            // A frame shorter than TotLen still ends the payload cleanly, but is flagged.
            if (s_axis.tlast) begin
              state <= IDLE;
              if (remaining != 16'd1) begin
                pkt_err  <= 1'b1;
                err_code <= 3'd5;
              end
            end else if (remaining == 16'd1) begin
              state <= DROP;
            end
          end
          DROP: begin
            if (s_axis.tlast)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_ipv4.sv
// Randomized and directed bench for rx_ipv4, scored against a frame-level model.
`timescale 1ns/1ps
module tb_rx_ipv4;

  typedef logic [7:0] bq_t[$];
  typedef logic [9:0] oq_t[$];

  localparam logic [31:0] LOCAL_IP = 32'hC0A80102;

  logic clk = 1'b0;
  logic s_axis_areset = 1'b1;
  logic ip_enable = 1'b1;
  logic [31:0] IP_SrcAddr, IP_DestAddr;
  logic [15:0] IP_TotLen;
  logic [7:0]  IP_Protocol, IP_TTL;
  logic [3:0]  IP_HdrLen;
  logic        pkt_ok, pkt_err;
  logic [2:0]  err_code;

  rx_ipv4_if s_if();
  rx_ipv4_if m_if();

  rx_ipv4 dut (
    .s_axis_aclk  (clk),
    .s_axis_areset(s_axis_areset),
    .ip_enable    (ip_enable),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .IP_SrcAddr   (IP_SrcAddr),
    .IP_DestAddr  (IP_DestAddr),
    .IP_TotLen    (IP_TotLen),
    .IP_Protocol  (IP_Protocol),
    .IP_TTL       (IP_TTL),
    .IP_HdrLen    (IP_HdrLen),
    .pkt_ok       (pkt_ok),
    .pkt_err      (pkt_err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  oq_t out_q;
  int ok_seen = 0, err_seen = 0;
  logic [2:0] last_err = '0;
  bit prev_stall = 0;
  logic [9:0] prev_word = '0;
  bit chk_stall = 0;
  int drv_idx = -1;
  bit rand_ready = 0;
  bit rdy_q[$];

  function automatic void checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_q.size() > 0) m_if.tready = rdy_q.pop_front();
      else if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
      else m_if.tready = 1'b1;
    end
  end

  // Output monitor: collects transfers, pulses, and checks output hold during stalls.
  always @(negedge clk) begin
    if (s_axis_areset || !ip_enable) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        checkValue("hold_while_stalled", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}, {1'b1, prev_word});
      if (m_if.tvalid && m_if.tready) out_q.push_back({m_if.tdata, m_if.tuser, m_if.tlast});
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_word  = {m_if.tdata, m_if.tuser, m_if.tlast};
      if (pkt_ok) ok_seen++;
      if (pkt_err) begin
        err_seen++;
        last_err = err_code;
      end
      if (chk_stall && drv_idx > 20 && drv_idx < 36)
        checkValue("s_tready_in_payload", s_if.tready, !m_if.tvalid || m_if.tready);
    end
  end

  function automatic bq_t buildFrame(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] totlen,
                                     input logic [7:0] proto, input logic [15:0] flags, input logic [31:0] src,
                                     input logic [31:0] dst, input logic [7:0] opt, input int npay,
                                     input int npad, input bit corrupt);
    bq_t f;
    int nh;
    int unsigned sum;
    logic [15:0] ck;
    nh = (ihl > 4'd5) ? 32'(ihl) * 4 : 20;
    f = {};
    f.push_back({ver, ihl});   f.push_back(8'h00);
    f.push_back(totlen[15:8]); f.push_back(totlen[7:0]);
    f.push_back(8'($urandom)); f.push_back(8'($urandom));
    f.push_back(flags[15:8]);  f.push_back(flags[7:0]);
    f.push_back(8'($urandom_range(1, 255))); f.push_back(proto);
    f.push_back(8'h00);        f.push_back(8'h00);
    for (int i = 3; i >= 0; i--) f.push_back(src[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) f.push_back(dst[i*8 +: 8]);
    for (int i = 20; i < nh; i++) f.push_back(opt);
    sum = 0;
    for (int w = 0; w < nh / 2; w++) sum += 32'({f[2*w], f[2*w+1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    f[10] = ck[15:8];
    f[11] = corrupt ? (ck[7:0] ^ 8'h01) : ck[7:0];
    for (int i = 0; i < npay + npad; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  // Frame-level model: decides the outcome from the header rules and slices the payload.
  task automatic predict(input bq_t f, output oq_t exp_q, output int exp_err, output bit exp_ok);
    int ver, ihl, hdr, len, totlen, rem, avail, n;
    int unsigned sum;
    logic [31:0] dst;
    exp_q = {};
    exp_err = 0;
    exp_ok = 0;
    ver = int'(f[0][7:4]);
    ihl = int'(f[0][3:0]);
    hdr = (ihl > 5) ? ihl * 4 : 20;
    len = f.size();
    if (len <= hdr) begin
      exp_err = 5;
      return;
    end
    totlen = int'({f[2], f[3]});
    sum = 0;
    for (int w = 0; w < ihl * 2; w++) sum += 32'({f[2*w], f[2*w+1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    dst = {f[16], f[17], f[18], f[19]};
    if (ver != 4 || ihl < 5 || totlen <= ihl * 4) exp_err = 1;
    else if (sum != 32'hFFFF) exp_err = 2;
    else if (f[9] != 8'h11 || (dst != LOCAL_IP && dst != 32'hFFFFFFFF)) exp_err = 3;
    else if (f[6][5] || {f[6][4:0], f[7]} != 13'd0) exp_err = 4;
    if (exp_err != 0) return;
    exp_ok = 1;
    rem = totlen - ihl * 4;
    avail = len - hdr;
    n = (avail < rem) ? avail : rem;
    for (int k = 0; k < n; k++) exp_q.push_back({f[hdr+k], (k == 0), (k == n - 1)});
    if (avail < rem) exp_err = 5;
  endtask

  task automatic applyStimulus(input bq_t f, input int from, input int to);
    bit acc;
    int guard;
    for (int i = from; i < to; i++) begin
      s_if.tdata  = f[i];
      s_if.tuser  = (i == 0);
      s_if.tlast  = (i == f.size() - 1);
      s_if.tvalid = 1'b1;
      drv_idx     = i;
      guard = 0;
      do begin
        @(negedge clk);
        acc = s_if.tready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) checkValue("accept_timeout", acc, 1'b1);
    end
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    drv_idx     = -1;
  endtask

  task automatic clearScore();
    out_q.delete();
    ok_seen = 0;
    err_seen = 0;
  endtask

  task automatic checkOutput(input bq_t f, input string tag);
    oq_t exp_q;
    int exp_err;
    bit exp_ok;
    int n;
    rand_ready = 0;
    rdy_q.delete();
    repeat (12) @(posedge clk);
    #1;
    predict(f, exp_q, exp_err, exp_ok);
    checkValue({tag, ".nbytes"}, 64'(out_q.size()), 64'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkValue($sformatf("%s.byte%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
    checkValue({tag, ".pkt_ok"}, 64'(ok_seen), 64'(exp_ok));
    checkValue({tag, ".pkt_err"}, 64'(err_seen), 64'(exp_err != 0));
    if (exp_err != 0) checkValue({tag, ".err_code"}, 64'(last_err), 64'(exp_err));
    if (exp_ok) begin
      checkValue({tag, ".src"}, 64'(IP_SrcAddr), 64'({f[12], f[13], f[14], f[15]}));
      checkValue({tag, ".dst"}, 64'(IP_DestAddr), 64'({f[16], f[17], f[18], f[19]}));
      checkValue({tag, ".totlen"}, 64'(IP_TotLen), 64'({f[2], f[3]}));
      checkValue({tag, ".proto"}, 64'(IP_Protocol), 64'(f[9]));
      checkValue({tag, ".ttl"}, 64'(IP_TTL), 64'(f[8]));
      checkValue({tag, ".hdrlen"}, 64'(IP_HdrLen), 64'(f[0][3:0]));
    end
    clearScore();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bq_t f;
    int start;
    int kind, npay, npad;
    logic [3:0] ver, ihl;
    logic [15:0] tot, flags;
    logic [7:0] proto;
    logic [31:0] dst;
    bit corrupt;

    s_if.tdata = '0; s_if.tvalid = 0; s_if.tlast = 0; s_if.tuser = 0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset.tvalid", m_if.tvalid, 1'b0);
    checkValue("reset.pulses", {pkt_ok, pkt_err, err_code}, 5'd0);
    checkValue("reset.fields", {IP_SrcAddr, IP_TotLen, IP_HdrLen}, 52'd0);
    s_axis_areset = 0;
    @(posedge clk);
    #1;
    checkValue("reset.s_tready", s_if.tready, 1'b1);

    // Basic frame with pad; header timing and pkt_ok latency checked directly.
    f = buildFrame(4'd4, 4'd5, 16'd36, 8'h11, 16'h4000, 32'hC0A8010A, LOCAL_IP, 8'h00, 16, 8, 0);
    start = cyc;
    applyStimulus(f, 0, 20);
    checkValue("basic.hdr_cycles", 64'(cyc - start), 64'd20);
    checkValue("basic.pkt_ok_timing", pkt_ok, 1'b1);
    applyStimulus(f, 20, f.size());
    checkOutput(f, "basic");
    checkValue("basic.src_const", IP_SrcAddr, 32'hC0A8010A);

    f = buildFrame(4'd4, 4'd5, 16'd36, 8'h11, 16'h4000, 32'hC0A8010A, LOCAL_IP, 8'h00, 16, 8, 1);
    applyStimulus(f, 0, f.size());
    checkOutput(f, "bad_csum");

    f = buildFrame(4'd4, 4'd6, 16'd40, 8'h11, 16'h0000, 32'h0A000001, LOCAL_IP, 8'h01, 16, 0, 0);
    applyStimulus(f, 0, f.size());
    checkOutput(f, "options");
    checkValue("options.hdrlen_const", IP_HdrLen, 4'd6);

    f = buildFrame(4'd4, 4'd6, 16'd40, 8'h11, 16'h0000, 32'h0A000001, 32'hC0A80199, 8'h01, 16, 0, 0);
    applyStimulus(f, 0, f.size());
    checkOutput(f, "bad_dst");

    // Downstream stall pattern 1-0-0-1 landing in the payload.
    f = buildFrame(4'd4, 4'd5, 16'd36, 8'h11, 16'h4000, 32'hC0A8010B, LOCAL_IP, 8'h00, 16, 0, 0);
    for (int i = 0; i < 22; i++) rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    chk_stall = 1;
    applyStimulus(f, 0, f.size());
    chk_stall = 0;
    checkOutput(f, "stall");

    f = buildFrame(4'd4, 4'd5, 16'd36, 8'h11, 16'h4000, 32'hC0A8010A, LOCAL_IP, 8'h00, 16, 0, 0);
    f = f[0:10];
    applyStimulus(f, 0, f.size());
    checkOutput(f, "tlast_hdr");

    f = buildFrame(4'd4, 4'd5, 16'd100, 8'h11, 16'h4000, 32'hC0A8010A, LOCAL_IP, 8'h00, 20, 0, 0);
    applyStimulus(f, 0, f.size());
    checkOutput(f, "short_payload");

    // Directed error classes and broadcast acceptance.
    f = buildFrame(4'd6, 4'd5, 16'd30, 8'h11, 16'h0000, 32'h01020304, LOCAL_IP, 8'h00, 10, 0, 0);
    applyStimulus(f, 0, f.size());  checkOutput(f, "bad_ver");
    f = buildFrame(4'd4, 4'd5, 16'd20, 8'h11, 16'h0000, 32'h01020304, LOCAL_IP, 8'h00, 4, 0, 0);
    applyStimulus(f, 0, f.size());  checkOutput(f, "totlen_eq_hdr");
    f = buildFrame(4'd4, 4'd5, 16'd30, 8'h11, 16'h2000, 32'h01020304, LOCAL_IP, 8'h00, 10, 0, 0);
    applyStimulus(f, 0, f.size());  checkOutput(f, "mf_set");
    f = buildFrame(4'd4, 4'd5, 16'd30, 8'h11, 16'h0001, 32'h01020304, LOCAL_IP, 8'h00, 10, 0, 0);
    applyStimulus(f, 0, f.size());  checkOutput(f, "frag_off");
    f = buildFrame(4'd4, 4'd5, 16'd30, 8'h06, 16'h0000, 32'h01020304, LOCAL_IP, 8'h00, 10, 0, 0);
    applyStimulus(f, 0, f.size());  checkOutput(f, "bad_proto");
    f = buildFrame(4'd4, 4'd5, 16'd21, 8'h11, 16'h0000, 32'h01020304, 32'hFFFFFFFF, 8'h00, 1, 3, 0);
    applyStimulus(f, 0, f.size());  checkOutput(f, "broadcast");

    // Reset during the fifth payload byte, then recovery on the next tuser.
    f = buildFrame(4'd4, 4'd5, 16'd36, 8'h11, 16'h4000, 32'hC0A8010A, LOCAL_IP, 8'h00, 16, 0, 0);
    applyStimulus(f, 0, 25);
    checkValue("rst_mid.pre_tvalid", m_if.tvalid, 1'b1);
    s_axis_areset = 1;
    #1;
    checkValue("rst_mid.tvalid", m_if.tvalid, 1'b0);
    checkValue("rst_mid.err_code", err_code, 3'd0);
    checkValue("rst_mid.src", IP_SrcAddr, 32'd0);
    @(posedge clk);
    #1;
    s_axis_areset = 0;
    clearScore();
    applyStimulus(f, 25, f.size());
    repeat (4) @(posedge clk);
    #1;
    checkValue("rst_mid.discard_bytes", 64'(out_q.size()), 64'd0);
    checkValue("rst_mid.discard_pulses", 64'(ok_seen + err_seen), 64'd0);
    f = buildFrame(4'd4, 4'd5, 16'd30, 8'h11, 16'h4000, 32'hC0A80177, LOCAL_IP, 8'h00, 10, 2, 0);
    applyStimulus(f, 0, f.size());
    checkOutput(f, "rst_recover");

    for (int r = 0; r < 24; r++) begin
      kind = $urandom_range(0, 9);
      ihl = 4'($urandom_range(5, 8));
      npay = $urandom_range(1, 24);
      npad = 0;
      tot = 16'(32'(ihl) * 4 + npay);
      ver = 4'd4; proto = 8'h11; flags = 16'h4000; dst = LOCAL_IP; corrupt = 0;
      case (kind)
        1: corrupt = 1;
        2: proto = 8'h06;
        3: dst = $urandom;
        4: flags = 16'h2000;
        5: flags = 16'h0001;
        6: tot = tot + 16'($urandom_range(1, 8));
        7: npad = $urandom_range(1, 10);
        8: dst = 32'hFFFFFFFF;
        9: ver = 4'd6;
        default: ;
      endcase
      f = buildFrame(ver, ihl, tot, proto, flags, $urandom, dst, 8'($urandom), npay, npad, corrupt);
      rand_ready = r[0];
      applyStimulus(f, 0, f.size());
      checkOutput(f, $sformatf("rnd%0d", r));
    end

    // Bypass: everything wired straight through.
    ip_enable = 0;
    rand_ready = 1;
    for (int i = 0; i < 8; i++) begin
      s_if.tdata = 8'($urandom); s_if.tvalid = 1'($urandom); s_if.tlast = 1'($urandom); s_if.tuser = 1'($urandom);
      @(negedge clk);
      checkValue("bypass", {m_if.tdata, m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready},
                 {s_if.tdata, s_if.tvalid, s_if.tlast, s_if.tuser, m_if.tready});
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 0; s_if.tlast = 0; s_if.tuser = 0;
    rand_ready = 0;
    ip_enable = 1;
    clearScore();
    f = buildFrame(4'd4, 4'd5, 16'd24, 8'h11, 16'h0000, 32'h0A0A0A0A, LOCAL_IP, 8'h00, 4, 0, 0);
    applyStimulus(f, 0, f.size());
    checkOutput(f, "after_bypass");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rx_ipv4.md
# rx_ipv4

Receive-side IPv4 header stripper: accepts byte-wide AXI-Stream frames (MAC header already removed, first IP byte flagged by tuser) and parses and validates the IPv4 header. It forwards only the IP payload, with tuser on the first payload byte and tlast on the last, directly into the UDP header parser stage. Frames that fail validation are consumed and dropped, and an error code is reported.

## Interface
- LOCAL_IP, 32'hC0A80102, accepted destination address (255.255.255.255 is always accepted)
- PROTOCOL, 8'h11, accepted protocol field
- CHECK_DEST, 1, 0 disables destination-address filtering
- s_axis_aclk  in  1  sole clock
- s_axis_areset  in  1  asynchronous, active-high reset
- ip_enable  in  1  0 = bypass: m_axis_* and s_axis_tready wired straight through, FSM held in IDLE
- s_axis_tdata/tvalid/tlast/tuser  in  8/1/1/1  input stream; tuser = first IP header byte
- s_axis_tready  out  1
- m_axis_tdata/tvalid/tlast/tuser  out  8/1/1/1  payload stream; tuser = first payload byte
- m_axis_tready  in  1
- IP_SrcAddr, IP_DestAddr  out  32  latched on accepted header
- IP_TotLen  out  16; IP_Protocol, IP_TTL  out  8; IP_HdrLen  out  4 (IHL)
- pkt_ok  out  1  one-cycle pulse, header accepted
- pkt_err  out  1  one-cycle pulse; err_code  out  3  valid with pkt_err, held until next error

## Operation
- States: IDLE, HEADER, OPTIONS, PAYLOAD, DROP. A byte is accepted when s_axis_tvalid & s_axis_tready.
- IDLE: tready=1. Accepted byte with tuser=1 is header byte 0 -> HEADER. Bytes without tuser are discarded. tuser is ignored outside IDLE.
- HEADER: tready=1; byte counter 0..19. Shadow-capture version/IHL (0), TotLen (2-3), flags/fragment offset (6-7), TTL (8), protocol (9), src (12-15), dst (16-19).
- Checksum: 16-bit one's-complement sum over all IHL*2 header words, including options. Carries are folded on every add, and a 17-bit accumulator is sufficient. Valid iff final sum == 16'hFFFF.
- After byte 19: if IHL>5 -> OPTIONS, which skips (IHL-5)*4 bytes while still summing. Then validate in priority order, err_code:
  - 1: version!=4, IHL<5, or TotLen<=IHL*4
  - 2: checksum bad
  - 3: protocol!=PROTOCOL, or dst mismatch with CHECK_DEST=1
  - 4: MF=1 or fragment offset!=0
- Pass -> commit shadow fields to outputs, pulse pkt_ok, go to PAYLOAD with remaining = TotLen-IHL*4 (16-bit). Fail -> pulse pkt_err, go to DROP.
- PAYLOAD: s_axis_tready = ~m_axis_tvalid | m_axis_tready (single output register). Each accepted byte is loaded into the output register and decrements remaining. m_axis_tuser=1 on the first byte only. m_axis_tlast=1 when remaining==1 or s_axis_tlast=1.
  - remaining==1 without s_axis_tlast -> DROP (Ethernet padding discarded).
  - s_axis_tlast with remaining>1 -> tlast emitted on that byte, err_code 5 pulsed, -> IDLE.
- DROP: tready=1, discard bytes until an accepted byte with tlast, then -> IDLE.
- s_axis_tlast in HEADER/OPTIONS -> err_code 5, -> IDLE; no output.

## Timing
- Reset values: all m_axis_* 0, pkt_ok/pkt_err 0, err_code 0, all field outputs 0, FSM IDLE. s_axis_tready is 1 once reset is released and ip_enable=1.
- pkt_ok/pkt_err assert the cycle after the last header/option byte is accepted.
- Payload latency: m_axis_tvalid rises 1 cycle after the byte is accepted. m_axis_tdata/tuser/tlast are held stable while tvalid & ~tready.
- Full throughput: one byte per cycle with m_axis_tready held high. A 20-byte header costs exactly 20 input cycles.
- Reset asserted mid-frame: outputs cleared immediately. After release, bytes up to the next tuser are discarded in IDLE.
- ip_enable is sampled continuously and changed only between frames; changing it mid-frame is undefined.

## Test plan
- IHL=5, TotLen=36, proto 0x11, src C0A8010A, dst C0A80102, correct checksum, plus 8 pad bytes with tlast on the final pad -> pkt_ok, 16 payload bytes out, tuser on byte 1, tlast on byte 16, pad dropped, IP_SrcAddr=C0A8010A.
- Same frame with header byte 11 (checksum low byte) XOR 0x01 -> pkt_err, err_code=2, no m_axis_tvalid, back to IDLE after tlast.
- IHL=6 with option 0x01010101, valid checksum, TotLen=40 -> 16 payload bytes out, IP_HdrLen=6; then dst C0A80199 with CHECK_DEST=1 -> err_code=3.
- Valid frame with m_axis_tready toggled 1-0-0-1 during payload -> no byte lost or duplicated, m_axis_tdata stable while stalled, s_axis_tready low while stalled.
- tlast on header byte 10; then TotLen=100 with only 20 payload bytes before tlast -> err_code=5 both times, second case emits 20 bytes with tlast on the 20th.
- Reset asserted during payload byte 5 -> m_axis_tvalid=0 immediately. Next frame with tuser is parsed correctly and pkt_ok is issued.
